pipe_game_ctrl: RTL and testbench

Parametrised fixed-point successor of the game-state controller for the terminal flappy-bird game. It runs the scene FSM, bird physics, N_PIPE scrolling pipes with pseudo-random gap recycling, collision detection and scoring. It sits between `io` (keystrokes, terminal size) and `view` (renderer), and drives the same `scene`/`bird`/`pipes` packing that `view` consumes.

---
 rtl/pipe_game_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_pipe_game_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_game_ctrl.sv
// pipe_game_ctrl: scene FSM, Q-format bird physics, N_PIPE scrolling pipes with
// LFSR gap recycling, collision detection and saturating score.
module pipe_game_ctrl #(
  parameter int N_PIPE       = 3,
  parameter int FRAC         = 8,
  parameter int VEL0         = 70,
  parameter int ACC1         = -4,
  parameter int ACC2         = -6,
  parameter int VEL_BND      = 26,
  parameter int PIPE_SPEED   = 77,
  parameter int PIPE_SPACING = 50,
  parameter int GAP_H        = 10,
  parameter int KP_BUFLEN    = 5,
  parameter int COLLIDE_EN   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           inp,
  input  logic [7:0]           n_row,
  input  logic [7:0]           n_col,
  output logic [1:0]           scene,
  output logic [8:0]           bird,
  output logic [24*N_PIPE-1:0] pipes,
  output logic [15:0]          score
);

  localparam int YW = 16 + FRAC;
  localparam int PW = 8 + FRAC;
  localparam int KB = KP_BUFLEN;

  typedef enum logic [1:0] {
    SPLASH   = 2'd0,
    PLAYING  = 2'd1,
    GAMEOVER = 2'd2
  } scene_t;

  localparam logic signed [15:0] C_VEL0     = 16'(VEL0);
  localparam logic signed [15:0] C_ACC1     = 16'(ACC1);
  localparam logic signed [15:0] C_ACC2     = 16'(ACC2);
  localparam logic signed [15:0] C_VBND     = 16'(VEL_BND);
  localparam logic [PW-1:0]      C_SPEED    = PW'(PIPE_SPEED);
  localparam logic [PW-1:0]      C_RECYC    = PW'((N_PIPE * PIPE_SPACING) << FRAC);
  localparam logic [7:0]         C_GAP_H    = 8'(GAP_H);
  localparam logic [7:0]         C_GAP_HALF = 8'(GAP_H / 2);
  localparam logic [15:0]        C_SEED     = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic [7:0] alt_of(input logic signed [YW-1:0] y);
    logic [7:0] alt;
    if (y[YW-1]) begin
      alt = 8'd0;
    end else begin
      alt = y[FRAC+7:FRAC];
    end
    return alt;
  endfunction

  function automatic logic [PW-1:0] pos_init(input int idx);
    return PW'(((idx + 1) * PIPE_SPACING) << FRAC);
  endfunction

  scene_t               r_scene;
  logic signed [YW-1:0] r_y;
  logic signed [15:0]   r_v;
  logic signed [15:0]   r_a;
  logic                 r_flap;
  logic [7:0]           r_alt;
  logic [PW-1:0]        r_pos [N_PIPE];
  logic [7:0]           r_min [N_PIPE];
  logic [7:0]           r_max [N_PIPE];
  logic [KB-1:0]        r_kpbuf;
  logic [15:0]          r_lfsr;
  logic [15:0]          r_score;

  scene_t               w_scene_nxt;
  logic                 w_keypress;
  logic                 w_flap;
  logic                 w_update;
  logic                 w_init;
  logic                 w_start;
  logic                 w_hit;
  logic signed [YW-1:0] w_y_init;
  logic signed [YW-1:0] w_y_sum;
  logic signed [YW-1:0] w_y_ceil;
  logic signed [YW-1:0] w_y_top;
  logic signed [YW-1:0] w_y_nxt;
  logic signed [15:0]   w_v_nxt;
  logic signed [15:0]   w_a_nxt;
  logic [7:0]           w_half;
  logic [7:0]           w_min_init;
  logic [7:0]           w_max_init;
  logic [7:0]           w_gap_min;
  logic [8:0]           w_row;
  logic [PW-1:0]        w_pos_nxt [N_PIPE];
  logic [N_PIPE-1:0]    w_recyc;
  logic [7:0]           w_nrec;
  logic [16:0]          w_score_sum;
  logic [15:0]          w_score_nxt;
  logic                 w_unused;

  assign w_keypress = (inp == 8'd32);
  assign w_flap     = |r_kpbuf;
  assign w_half     = {1'b0, n_row[7:1]};
  assign w_min_init = w_half - C_GAP_HALF;
  assign w_max_init = w_min_init + C_GAP_H;
  assign w_y_init   = {{(YW-8-FRAC){1'b0}}, w_half, {FRAC{1'b0}}};
  assign w_y_ceil   = {{(YW-8-FRAC){1'b0}}, n_row, {FRAC{1'b0}}};
  assign w_y_top    = {{(YW-8-FRAC){1'b0}}, n_row - 8'd1, {FRAC{1'b0}}};
  assign w_y_sum    = r_y + YW'(r_v);
  assign w_unused   = ^n_col;

  // Collision: bird row must lie strictly inside the gap of every pipe at the bird column.
  always_comb begin
    w_hit = 1'b0;
    w_row = {1'b0, n_row} - {1'b0, r_alt};
    for (int i = 0; i < N_PIPE; i++) begin
      if ((COLLIDE_EN != 0) && (r_pos[i][FRAC+7:FRAC] <= 8'd6) &&
          !(({1'b0, r_min[i]} < w_row) && (w_row < {1'b0, r_max[i]}))) begin
        w_hit = 1'b1;
      end else begin
        w_hit = w_hit;
      end
    end
  end

  // Scene next-state; updates are gated on the next scene so death freezes at once.
  always_comb begin
    w_scene_nxt = r_scene;
    case (r_scene)
      SPLASH:   if (w_keypress) w_scene_nxt = PLAYING;  else w_scene_nxt = SPLASH;
      PLAYING:  if (r_y[YW-1] || w_hit) w_scene_nxt = GAMEOVER; else w_scene_nxt = PLAYING;
      GAMEOVER: if (w_keypress) w_scene_nxt = SPLASH;   else w_scene_nxt = GAMEOVER;
      default:  w_scene_nxt = SPLASH;
    endcase
    w_update = (r_scene == PLAYING)  && (w_scene_nxt == PLAYING);
    w_init   = (r_scene == GAMEOVER) && (w_scene_nxt == SPLASH);
    w_start  = (r_scene == SPLASH)   && (w_scene_nxt == PLAYING);
  end

  // Bird physics from old values, with the ceiling clamp.
  always_comb begin
    w_a_nxt = (r_v > C_VBND) ? C_ACC1 : C_ACC2;
    w_v_nxt = w_flap ? C_VEL0 : (r_v + r_a);
    w_y_nxt = w_y_sum;
    if (w_y_sum >= w_y_ceil) begin
      w_y_nxt = w_y_top;
      w_v_nxt = 16'sd0;
    end else begin
      w_y_nxt = w_y_sum;
    end
  end

  // Pipe scroll and recycle; all recycles in one cycle share the same gap draw.
  always_comb begin
    w_recyc   = '0;
    w_nrec    = 8'd0;
    w_gap_min = 8'd2 + {3'b000, r_lfsr[4:0]};
    if (({1'b0, w_gap_min} + {1'b0, C_GAP_H}) > ({1'b0, n_row} - 9'd2)) begin
      w_gap_min = n_row - 8'd2 - C_GAP_H;
    end else begin
      w_gap_min = w_gap_min;
    end
    for (int i = 0; i < N_PIPE; i++) begin
      w_pos_nxt[i] = r_pos[i];
      if (r_pos[i] >= C_SPEED) begin
        w_pos_nxt[i] = r_pos[i] - C_SPEED;
      end else begin
        w_pos_nxt[i] = C_RECYC;
        w_recyc[i]   = 1'b1;
        w_nrec       = w_nrec + 8'd1;
      end
    end
    w_score_sum = {1'b0, r_score} + {9'd0, w_nrec};
    w_score_nxt = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
  end

  // Scene register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_scene <= SPLASH;
    else        r_scene <= w_scene_nxt;
  end

  // Free-running LFSR, reseeded only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) r_lfsr <= C_SEED;
    else        r_lfsr <= lfsr_step(r_lfsr);
  end

  // Keypress stretcher.
  always_ff @(posedge clk) begin
    if (!rst_n || w_init) r_kpbuf <= '0;
    else                  r_kpbuf <= KB'({w_keypress, r_kpbuf} >> 1);
  end

  // Bird state.
  always_ff @(posedge clk) begin
    if (!rst_n || w_init) begin
      r_y    <= w_y_init;
      r_v    <= C_VEL0;
      r_a    <= C_ACC1;
      r_flap <= 1'b0;
      r_alt  <= w_half;
    end else if (w_update) begin
      r_y    <= w_y_nxt;
      r_v    <= w_v_nxt;
      r_a    <= w_a_nxt;
      r_flap <= w_flap;
      r_alt  <= alt_of(w_y_nxt);
    end
  end

  // Pipe state.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_PIPE; i++) begin
      if (!rst_n || w_init) begin
        r_pos[i] <= pos_init(i);
        r_min[i] <= w_min_init;
        r_max[i] <= w_max_init;
      end else if (w_update) begin
        r_pos[i] <= w_pos_nxt[i];
        if (w_recyc[i]) begin
          r_min[i] <= w_gap_min;
          r_max[i] <= w_gap_min + C_GAP_H;
        end
      end
    end
  end

  // Score survives GAMEOVER->SPLASH and clears on a new round.
  always_ff @(posedge clk) begin
    if (!rst_n || w_start) r_score <= 16'd0;
    else if (w_update)     r_score <= w_score_nxt;
  end

  assign scene = r_scene;
  assign bird  = {r_alt, r_flap};
  assign score = r_score;

  // Pack pipes for the renderer.
  always_comb begin
    pipes = '0;
    for (int i = 0; i < N_PIPE; i++) begin
      pipes[24*i +: 24] = {r_pos[i][FRAC+7:FRAC], r_max[i], r_min[i]};
    end
  end

endmodule

// File: tb/tb_pipe_game_ctrl.sv
// Directed bench for pipe_game_ctrl: reset, flap/fall physics, floor death,
// pipe collision, pipe recycling with scoring, and the GAMEOVER->SPLASH path.
module tb_pipe_game_ctrl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  inp, inp_nc;
  logic [7:0]  n_row, n_col;
  logic [1:0]  scene, scene_nc;
  logic [8:0]  bird, bird_nc;
  logic [71:0] pipes, pipes_nc;
  logic [15:0] score, score_nc;

  int n_chk = 0;
  int n_err = 0;

  pipe_game_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .inp(inp), .n_row(n_row), .n_col(n_col),
    .scene(scene), .bird(bird), .pipes(pipes), .score(score)
  );

  pipe_game_ctrl #(.COLLIDE_EN(0)) u_dut_nc (
    .clk(clk), .rst_n(rst_n), .inp(inp_nc), .n_row(n_row), .n_col(n_col),
    .scene(scene_nc), .bird(bird_nc), .pipes(pipes_nc), .score(score_nc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pos_f(input logic [71:0] p, input int i);
    return p[24*i+16 +: 8];
  endfunction
  function automatic logic [7:0] max_f(input logic [71:0] p, input int i);
    return p[24*i+8 +: 8];
  endfunction
  function automatic logic [7:0] min_f(input logic [71:0] p, input int i);
    return p[24*i +: 8];
  endfunction

  int          my, mv, ma, ny, nv, na, malt, peak;
  logic [4:0]  mkp;
  logic        mflap, dead;
  logic [71:0] p_save;
  logic [8:0]  b_save;

  initial begin
    clk = 1'b0; rst_n = 1'b0; inp = 8'd0; inp_nc = 8'd0;
    n_row = 8'd24; n_col = 8'd80;
    tick(); tick();

    check("rst_scene", scene, 2'd0);
    check("rst_bird", bird, {8'd12, 1'b0});
    check("rst_pos0", pos_f(pipes, 0), 8'd50);
    check("rst_pos1", pos_f(pipes, 1), 8'd100);
    check("rst_pos2", pos_f(pipes, 2), 8'd150);
    check("rst_min0", min_f(pipes, 0), 8'd7);
    check("rst_max2", max_f(pipes, 2), 8'd17);
    check("rst_score", score, 16'd0);
    rst_n = 1'b1;
    tick();
    check("idle_scene", scene, 2'd0);

    // Single flap, then free fall to the floor, tracked by a reference model.
    inp = 8'd32; tick(); inp = 8'd0;
    check("start_scene", scene, 2'd1);
    check("start_bird", bird, {8'd12, 1'b0});
    my = 12 * 256; mv = 70; ma = -4; mkp = 5'b10000; peak = 0; dead = 1'b0;
    for (int n = 1; n <= 300 && !dead; n++) begin
      tick();
      mflap = |mkp;
      na = (mv > 26) ? -4 : -6;
      nv = mflap ? 70 : mv + ma;
      ny = my + mv;
      if (ny >= 24 * 256) begin
        ny = 23 * 256;
        nv = 0;
      end
      my = ny; mv = nv; ma = na;
      mkp = mkp >> 1;
      malt = (my < 0) ? 0 : ((my >>> 8) & 255);
      check("fall_alt", bird[8:1], malt);
      check("fall_flap", bird[0], mflap);
      if (malt > peak) peak = malt;
      if (my < 0) dead = 1'b1;
    end
    check("floor_reached", dead, 1'b1);
    check("peak_above_start", peak > 12, 1'b1);
    check("scene_before_death", scene, 2'd1);
    p_save = pipes;
    tick();
    check("floor_gameover", scene, 2'd2);
    check("no_update_at_death", pipes, p_save);
    p_save = pipes; b_save = bird;
    for (int n = 0; n < 50; n++) begin
      tick();
      check("frozen", {scene, bird, pipes}, {2'd2, b_save, p_save});
    end

    // Held space keeps the bird at the ceiling until pipe0 reaches column 6.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    inp = 8'd32; tick();
    check("hold_start", scene, 2'd1);
    for (int n = 1; n <= 142; n++) tick();
    check("hold_pos_142", pos_f(pipes, 0), 8'd7);
    check("hold_alive_142", scene, 2'd1);
    tick();
    inp = 8'd0;
    check("hit_pos_143", pos_f(pipes, 0), 8'd6);
    check("hit_alt", bird[8:1], 8'd23);
    check("hit_scene_pre", scene, 2'd1);
    tick();
    check("hit_gameover", scene, 2'd2);
    check("hit_pos_frozen", pos_f(pipes, 0), 8'd6);
    check("hit_score", score, 16'd0);

    // No collision: space every 20 cycles, pipe0 recycles on update 167.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    inp_nc = 8'd32; tick();
    for (int n = 1; n <= 166; n++) begin
      inp_nc = (n % 20 == 0) ? 8'd32 : 8'd0;
      tick();
    end
    inp_nc = 8'd0;
    check("nc_alive_166", scene_nc, 2'd1);
    check("nc_pos0_166", pos_f(pipes_nc, 0), 8'd0);
    check("nc_score_166", score_nc, 16'd0);
    tick();
    check("nc_pos0_167", pos_f(pipes_nc, 0), 8'd150);
    check("nc_pos1_167", pos_f(pipes_nc, 1), 8'd49);
    check("nc_pos2_167", pos_f(pipes_nc, 2), 8'd99);
    check("nc_score_167", score_nc, 16'd1);
    check("nc_min_ge2", min_f(pipes_nc, 0) >= 8'd2, 1'b1);
    check("nc_max_le22", max_f(pipes_nc, 0) <= 8'd22, 1'b1);
    check("nc_gap_h", max_f(pipes_nc, 0) - min_f(pipes_nc, 0), 8'd10);

    dead = 1'b0;
    for (int n = 0; n < 400 && !dead; n++) begin
      tick();
      if (scene_nc == 2'd2) dead = 1'b1;
    end
    check("nc_floor_gameover", dead, 1'b1);
    check("nc_score_held", score_nc, 16'd1);

    inp_nc = 8'd32; tick(); inp_nc = 8'd0;
    check("go_splash", scene_nc, 2'd0);
    check("go_bird", bird_nc, {8'd12, 1'b0});
    check("go_pos0", pos_f(pipes_nc, 0), 8'd50);
    check("go_pos2", pos_f(pipes_nc, 2), 8'd150);
    check("go_min0", min_f(pipes_nc, 0), 8'd7);
    check("go_max0", max_f(pipes_nc, 0), 8'd17);
    check("go_score_held", score_nc, 16'd1);
    tick();
    check("go_stay_splash", scene_nc, 2'd0);
    inp_nc = 8'd32; tick(); inp_nc = 8'd0;
    check("restart_scene", scene_nc, 2'd1);
    check("restart_score", score_nc, 16'd0);

    // Reset in the middle of a round.
    tick(); tick(); tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("midrst_scene", scene_nc, 2'd0);
    check("midrst_bird", bird_nc, {8'd12, 1'b0});
    check("midrst_pos0", pos_f(pipes_nc, 0), 8'd50);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
